// File: rtl/kf_pkg.sv
// Shared constants and FSM encoding for the Kalman filter channel scheduler,
// its context store and the filter core.
package kf_pkg;

    localparam int FRAC       = 12;
    localparam int X_ADDR_DEF = 16;
    localparam int Z_ADDR_DEF = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_X,
        ST_LOAD_Z,
        ST_START,
        ST_WAIT_BUSY,
        ST_RUN,
        ST_EMIT
    } kf_state_e;

endpackage

// File: rtl/kf_ctx_store.sv
// Per-channel estimate context: NCH x W registers, one write port,
// asynchronous read, and a bulk clear back to INIT_X.
module kf_ctx_store #(
    parameter int          W      = 24,
    parameter int          NCH    = 4,
    parameter logic [W-1:0] INIT_X = '0,
    localparam int         CHW    = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr_i,
    input  logic           we_i,
    input  logic [CHW-1:0] waddr_i,
    input  logic [W-1:0]   wdata_i,
    input  logic [CHW-1:0] raddr_i,
    output logic [W-1:0]   rdata_o
);

    logic [W-1:0] ctx_q [NCH];

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            for (int i = 0; i < NCH; i++) begin
                ctx_q[i] <= INIT_X;
            end
        end else if (we_i) begin
            ctx_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = ctx_q[raddr_i];

endmodule

// File: rtl/kf_chan_sched.sv
// Time-multiplexes one Kalman filter core across NCH scalar channels: restores
// the channel estimate, loads the measurement, runs the core under a watchdog.
module kf_chan_sched
    import kf_pkg::*;
#(
    parameter int               W       = 24,
    parameter int               ADDRW   = 5,
    parameter int               NCH     = 4,
    parameter logic [ADDRW-1:0] X_ADDR  = ADDRW'(X_ADDR_DEF),
    parameter logic [ADDRW-1:0] Z_ADDR  = ADDRW'(Z_ADDR_DEF),
    parameter logic [W-1:0]     INIT_X  = '0,
    parameter int               TMO_CYC = 1023,
    localparam int              CHW     = $clog2(NCH),
    localparam int              WDW     = $clog2(TMO_CYC + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctx_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CHW-1:0]   in_ch,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CHW-1:0]   out_ch,
    output logic [W-1:0]     out_data,
    output logic             out_err,
    output logic             busy,
    output logic             kf_start,
    output logic             kf_write,
    output logic [ADDRW-1:0] kf_dir,
    output logic [W-1:0]     kf_data_in,
    input  logic             kf_ready,
    input  logic [W-1:0]     kf_data_out
);

    // Both streams transfer on a rising edge where valid and ready are both
    // high; a raised out_valid holds its payload unchanged until out_ready.

    kf_state_e        state_q, state_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic [W-1:0]     z_q, z_d;
    logic [WDW-1:0]   wdog_q, wdog_d;
    logic             out_valid_q, out_valid_d;
    logic [CHW-1:0]   out_ch_q, out_ch_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic             out_err_q, out_err_d;
    logic             kf_start_q, kf_start_d;
    logic             kf_write_q, kf_write_d;
    logic [ADDRW-1:0] kf_dir_q, kf_dir_d;
    logic [W-1:0]     kf_data_in_q, kf_data_in_d;

    logic             accept;
    logic             wdog_hit;
    logic             ctx_we;
    logic             ctx_clr_en;
    logic [W-1:0]     ctx_rdata;
    logic [CHW-1:0]   ch_map;

    // Out-of-range tags fold onto a real channel instead of being rejected.
    assign ch_map   = CHW'(int'(in_ch) % NCH);
    assign in_ready = !rst && (state_q == ST_IDLE) && !ctx_clr && kf_ready;
    assign accept   = in_valid && in_ready;
    assign wdog_hit = (wdog_q == WDW'(TMO_CYC - 1));
    assign ctx_clr_en = ctx_clr && (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);

    kf_ctx_store #(
        .W      (W),
        .NCH    (NCH),
        .INIT_X (INIT_X)
    ) u_ctx (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (ctx_clr_en),
        .we_i    (ctx_we),
        .waddr_i (ch_q),
        .wdata_i (kf_data_out),
        .raddr_i (ch_d),
        .rdata_o (ctx_rdata)
    );

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        z_d         = z_q;
        wdog_d      = wdog_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        ctx_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ch_d    = ch_map;
                    z_d     = in_data;
                    state_d = ST_LOAD_X;
                end
            end
            ST_LOAD_X: state_d = ST_LOAD_Z;
            ST_LOAD_Z: state_d = ST_START;
            ST_START: begin
                wdog_d  = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                wdog_d = wdog_q + WDW'(1);
                if (!kf_ready) begin
                    state_d = ST_RUN;
                end else if (wdog_hit) begin
                    out_valid_d = 1'b1;
                    out_ch_d    = ch_q;
                    out_data_d  = ctx_rdata;
                    out_err_d   = 1'b1;
                    state_d     = ST_EMIT;
                end
            end
            ST_RUN: begin
                wdog_d = wdog_q + WDW'(1);
                // A completing core wins over an expiring watchdog.
                if (kf_ready) begin
                    out_valid_d = 1'b1;
                    out_ch_d    = ch_q;
                    out_data_d  = kf_data_out;
                    out_err_d   = 1'b0;
                    ctx_we      = 1'b1;
                    state_d     = ST_EMIT;
                end else if (wdog_hit) begin
                    out_valid_d = 1'b1;
                    out_ch_d    = ch_q;
                    out_data_d  = ctx_rdata;
                    out_err_d   = 1'b1;
                    state_d     = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Core strobes are registered from the next state so they line up
        // with the cycle that state occupies.
        kf_write_d   = (state_d == ST_LOAD_X) || (state_d == ST_LOAD_Z);
        kf_start_d   = (state_d == ST_START);
        kf_dir_d     = '0;
        kf_data_in_d = '0;
        if (state_d == ST_LOAD_X) begin
            kf_dir_d     = X_ADDR;
            kf_data_in_d = ctx_rdata;
        end else if (state_d == ST_LOAD_Z) begin
            kf_dir_d     = Z_ADDR;
            kf_data_in_d = z_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            z_q          <= '0;
            wdog_q       <= '0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_data_q   <= '0;
            out_err_q    <= 1'b0;
            kf_start_q   <= 1'b0;
            kf_write_q   <= 1'b0;
            kf_dir_q     <= '0;
            kf_data_in_q <= '0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            z_q          <= z_d;
            wdog_q       <= wdog_d;
            out_valid_q  <= out_valid_d;
            out_ch_q     <= out_ch_d;
            out_data_q   <= out_data_d;
            out_err_q    <= out_err_d;
            kf_start_q   <= kf_start_d;
            kf_write_q   <= kf_write_d;
            kf_dir_q     <= kf_dir_d;
            kf_data_in_q <= kf_data_in_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign out_data   = out_data_q;
    assign out_err    = out_err_q;
    assign kf_start   = kf_start_q;
    assign kf_write   = kf_write_q;
    assign kf_dir     = kf_dir_q;
    assign kf_data_in = kf_data_in_q;

endmodule

// File: tb/tb_kf_chan_sched.sv
// Self-checking bench for kf_chan_sched: behavioural core model, per-channel
// reference contexts and randomized traffic.
module tb_kf_chan_sched;

  localparam int W     = 24;
  localparam int ADDRW = 5;
  localparam int NCH   = 4;
  localparam int CHW   = 2;
  localparam int TMO   = 15;
  localparam logic [ADDRW-1:0] XA = 5'd16;
  localparam logic [ADDRW-1:0] ZA = 5'd0;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             ctx_clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [CHW-1:0]   in_ch = '0;
  logic [W-1:0]     in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CHW-1:0]   out_ch;
  logic [W-1:0]     out_data;
  logic             out_err;
  logic             busy;
  logic             kf_start;
  logic             kf_write;
  logic [ADDRW-1:0] kf_dir;
  logic [W-1:0]     kf_data_in;
  logic             kf_ready = 1'b1;
  logic [W-1:0]     kf_data_out = '0;

  kf_chan_sched #(
    .W(W), .ADDRW(ADDRW), .NCH(NCH), .X_ADDR(XA), .Z_ADDR(ZA),
    .INIT_X('0), .TMO_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .ctx_clr(ctx_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_data(out_data), .out_err(out_err), .busy(busy),
    .kf_start(kf_start), .kf_write(kf_write), .kf_dir(kf_dir),
    .kf_data_in(kf_data_in), .kf_ready(kf_ready), .kf_data_out(kf_data_out)
  );

  // core model: READY drops k cycles after START, stays low n cycles
  int         core_k = 1;
  int         core_n = 10;
  bit         core_never = 1'b0;
  bit         core_sum = 1'b0;
  int         core_c = 0;
  int         core_nx;
  logic [W-1:0] bank [32];

  always @(posedge clk) begin
    if (kf_write) bank[kf_dir] <= kf_data_in;
    core_nx = core_c;
    if (kf_start && !core_never) core_nx = 1;
    else if (core_c != 0) core_nx = core_c + 1;
    if (core_nx != 0 && core_nx >= core_k && core_nx < core_k + core_n) kf_ready <= 1'b0;
    else kf_ready <= 1'b1;
    if (core_nx != 0 && core_nx == core_k + core_n) begin
      kf_data_out <= core_sum ? bank[XA] + bank[ZA] : bank[ZA] + 24'd1;
      core_nx = 0;
    end
    core_c <= core_nx;
  end

  // core-bus monitor
  typedef struct { int c; logic [ADDRW-1:0] dir; logic [W-1:0] data; } wr_t;
  wr_t wlog[$];
  int  start_cyc = -1;
  int  n_start = 0;
  int  ns0_g = 0;
  always @(negedge clk) begin
    if (kf_write) wlog.push_back('{cyc, kf_dir, kf_data_in});
    if (kf_start) begin
      start_cyc = cyc;
      n_start++;
    end
  end

  // scoreboard
  int n_chk = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] ref_ctx [NCH];
  int           idx_g;
  logic [W-1:0] exp_x_g, exp_z_g, res_g;
  bit           ok_g;
  bit           exp_err_g;
  int           exp_lat_g;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // reference model: estimate update and completion time from the rules
  task automatic predict(input int ch, input logic [W-1:0] z, input int k, input int n,
                         input bit never, input bit sum);
    idx_g     = ch % NCH;
    exp_x_g   = ref_ctx[idx_g];
    exp_z_g   = z;
    ok_g      = !never && (k + n <= TMO);
    res_g     = sum ? exp_x_g + z : z + 24'd1;
    exp_q.push_back(ok_g ? res_g : exp_x_g);
    exp_err_g = !ok_g;
    exp_lat_g = ok_g ? k + n + 4 : TMO + 4;
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while (!(busy === 1'b0 && kf_ready === 1'b1 && core_c == 0) && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("idle_reached", w < 300, 1);
  endtask

  task automatic set_core(input int k, input int n, input bit never, input bit sum);
    core_k = k;
    core_n = n;
    core_never = never;
    core_sum = sum;
  endtask

  // driver: offer one measurement, return the cycle index before LOAD_X
  task automatic send(input int ch, input logic [W-1:0] z, input int k, input int n,
                      input bit never, input bit sum, output int t0);
    wait_idle();
    check("in_ready_idle", in_ready, 1);
    set_core(k, n, never, sum);
    wlog.delete();
    ns0_g    = n_start;
    in_valid = 1'b1;
    in_ch    = CHW'(ch);
    in_data  = z;
    @(negedge clk);
    in_valid = 1'b0;
    t0 = cyc - 1;
  endtask

  task automatic collect(input int t0, input int hold);
    int w = 0;
    bit moved = 1'b0;
    logic [W-1:0] d0;
    logic [CHW-1:0] c0;
    logic e0;
    while (out_valid !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("out_valid_seen", out_valid, 1);
    check("latency", cyc - t0, exp_lat_g);
    check("out_ch", out_ch, idx_g);
    check("out_data", out_data, exp_q.pop_front());
    check("out_err", out_err, exp_err_g);
    check("wr_count", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("ldx_dir", wlog[0].dir, XA);
      check("ldx_data", wlog[0].data, exp_x_g);
      check("ldx_cyc", wlog[0].c, t0 + 1);
      check("ldz_dir", wlog[1].dir, ZA);
      check("ldz_data", wlog[1].data, exp_z_g);
      check("ldz_cyc", wlog[1].c, t0 + 2);
    end
    check("start_cnt", n_start - ns0_g, 1);
    check("start_cyc", start_cyc, t0 + 3);
    d0 = out_data;
    c0 = out_ch;
    e0 = out_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== d0 || out_ch !== c0 || out_err !== e0) moved = 1'b1;
      if (in_ready !== 1'b0) moved = 1'b1;
    end
    if (hold > 0) check("hold_stable", moved, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("busy_after_emit", busy, 0);
    if (ok_g) ref_ctx[idx_g] = res_g;
  endtask

  task automatic run_txn(input int ch, input logic [W-1:0] z, input int k, input int n,
                         input bit never, input bit sum, input int hold);
    int t0;
    predict(ch, z, k, n, never, sum);
    send(ch, z, k, n, never, sum, t0);
    collect(t0, hold);
  endtask

  task automatic clr_pulse();
    wait_idle();
    ctx_clr = 1'b1;
    @(negedge clk);
    ctx_clr = 1'b0;
    for (int i = 0; i < NCH; i++) ref_ctx[i] = '0;
  endtask

  initial begin
    int  t0;
    int  w;
    bit  early;
    for (int i = 0; i < NCH; i++) ref_ctx[i] = '0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_kf_bus", {kf_start, kf_write, kf_dir, kf_data_in}, 0);
    rst = 1'b0;
    #1 check("post_rst_in_ready", in_ready, 1);

    // nominal: ch2, z=0x100, core returns z+1
    run_txn(2, 24'h000100, 1, 10, 1'b0, 1'b0, 0);
    // ctx[2] restored on the next visit
    run_txn(2, 24'h000003, 1, 6, 1'b0, 1'b1, 0);
    // watchdog: core never drops READY
    run_txn(2, 24'h000055, 1, 1, 1'b1, 1'b0, 0);
    run_txn(2, 24'h000001, 2, 3, 1'b0, 1'b1, 0);
    // output backpressure
    run_txn(1, 24'h000010, 2, 5, 1'b0, 1'b0, 10);

    // context isolation
    clr_pulse();
    run_txn(0, 24'd5, 1, 4, 1'b0, 1'b1, 0);
    run_txn(1, 24'd9, 1, 4, 1'b0, 1'b1, 0);
    run_txn(0, 24'd7, 1, 4, 1'b0, 1'b1, 0);

    // clear and valid in the same IDLE cycle
    wait_idle();
    for (int i = 0; i < NCH; i++) ref_ctx[i] = '0;
    predict(1, 24'h00002a, 2, 4, 1'b0, 1'b1);
    set_core(2, 4, 1'b0, 1'b1);
    wlog.delete();
    ns0_g    = n_start;
    ctx_clr  = 1'b1;
    in_valid = 1'b1;
    in_ch    = 2'd1;
    in_data  = 24'h00002a;
    #1 check("clr_blocks_ready", in_ready, 0);
    @(negedge clk);
    ctx_clr = 1'b0;
    #1 check("no_accept_on_clr", busy, 0);
    check("ready_after_clr", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    t0 = cyc - 1;
    collect(t0, 0);

    // reset while the core is running
    run_txn(3, 24'h000020, 1, 3, 1'b0, 1'b0, 0);
    send(3, 24'h000077, 1, 40, 1'b0, 1'b0, t0);
    repeat (5) @(negedge clk);
    check("mid_run_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    for (int i = 0; i < NCH; i++) ref_ctx[i] = '0;
    w = 0;
    early = 1'b0;
    while (kf_ready !== 1'b1 && w < 100) begin
      if (in_ready !== 1'b0) early = 1'b1;
      @(negedge clk);
      w++;
    end
    check("mid_rst_no_early_ready", early, 0);
    check("ready_after_core", in_ready, 1);
    run_txn(3, 24'h000010, 1, 3, 1'b0, 1'b1, 0);
    run_txn(2, 24'h000004, 1, 3, 1'b0, 1'b1, 0);

    // randomized traffic
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 7) == 0) clr_pulse();
      run_txn($urandom_range(0, NCH - 1), W'($urandom), $urandom_range(1, 3),
              $urandom_range(1, 16), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
